// File: rtl/counter_if.sv
// rtl/counter_if.sv - count bus bundle for the free-running counter
interface counter_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] q;

    modport master (output q);
    modport slave  (input  q);
endinterface

// File: rtl/counter.sv
// rtl/counter.sv - free-running up-counter with async active-low clear
// COUNTER_JK_STRUCT_EN selects the JK-stage structural build; default is behavioural.
module counter #(
    parameter int WIDTH = 4
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             reset
);

`ifdef COUNTER_JK_STRUCT_EN
    // carry[i] is the AND of all bits below stage i; stage 0 always toggles
    logic [WIDTH-1:0] carry;

    assign carry[0] = 1'b1;

    genvar g;
    generate
        for (g = 1; g < WIDTH; g++) begin : g_carry
            and u_and (carry[g], carry[g-1], q[g-1]);
        end

        for (g = 0; g < WIDTH; g++) begin : g_stage
            logic j;
            logic k;
            logic stage_q;

            assign j = carry[g];
            assign k = carry[g];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    stage_q <= 1'b0;
                end else begin
                    case ({j, k})
                        2'b11:   stage_q <= ~stage_q;
                        2'b10:   stage_q <= 1'b1;
                        2'b01:   stage_q <= 1'b0;
                        default: stage_q <= stage_q;
                    endcase
                end
            end

            assign q[g] = stage_q;
        end
    endgenerate
`else
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign q = count;
`endif

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - scoreboard bench for counter at WIDTH=4 and WIDTH=8
module tb_counter;

    logic clk;
    logic reset;

    counter_if #(.WIDTH(4)) cif4 ();
    counter_if #(.WIDTH(8)) cif8 ();

    counter #(.WIDTH(4)) dut4 (
        .q     (cif4.q),
        .clk   (clk),
        .reset (reset)
    );

    counter #(.WIDTH(8)) dut8 (
        .q     (cif8.q),
        .clk   (clk),
        .reset (reset)
    );

    // rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] e4;
        logic [7:0] e8;
    } exp_t;

    exp_t exp_q[$];
    event chk;
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic wait_until(input int t);
        if ($time < t) #(t - $time);
    endtask

    task automatic expect_q(input string name, input int n);
        exp_t e;
        e.name = name;
        e.e4   = 4'(n % 16);
        e.e8   = 8'(n % 256);
        exp_q.push_back(e);
        -> chk;
    endtask

    // monitor: pops one expectation per strobe and compares both widths
    initial begin
        exp_t e;
        forever begin
            @(chk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (cif4.q !== e.e4) begin
                    errors++;
                    $display("FAIL %s w4 t=%0t q=%0d expected=%0d", e.name, $time, cif4.q, e.e4);
                end
                checks++;
                if (cif8.q !== e.e8) begin
                    errors++;
                    $display("FAIL %s w8 t=%0t q=%0d expected=%0d", e.name, $time, cif8.q, e.e8);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;

        // power-up: held in clear across edges at 10 and 30
        wait_until(5);   expect_q("por_t5", 0);
        wait_until(20);  expect_q("por_t20", 0);
        wait_until(34);  reset = 1'b1;
        wait_until(40);  expect_q("release_pre_edge", 0);

        // edges 50..210 give 1..9
        for (int k = 1; k <= 9; k++) begin
            wait_until(40 + 20 * k);
            expect_q("count", k);
        end

        // edge at 230 gives 10, then async clear between edges
        wait_until(232); expect_q("pre_clear", 10);
        wait_until(234); reset = 1'b0;
        #1;              expect_q("async_clear", 0);
        wait_until(240); expect_q("hold_clear_a", 0);
        wait_until(260); expect_q("hold_clear_b", 0);
        wait_until(280); expect_q("hold_clear_c", 0);
        wait_until(284); reset = 1'b1;

        // edge at 290 gives 1; run through 4-bit and 8-bit wrap
        for (int j = 0; j <= 257; j++) begin
            wait_until(300 + 20 * j);
            if (j + 1 == 15 || j + 1 == 16 || j + 1 == 17)
                expect_q("wrap4", j + 1);
            else if (j + 1 == 255 || j + 1 == 256 || j + 1 == 257)
                expect_q("wrap8", j + 1);
            else
                expect_q("rerelease_count", j + 1);
        end

        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", exp_q.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        if (!done) begin
            $display("FAIL watchdog t=%0t expected=finish_before_20000", $time);
            $fatal(1);
        end
    end

endmodule
